// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 width codes,
// FSM state encoding and request legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Stores only exist for byte, halfword and word; loads add the
    // unsigned byte/halfword forms.
    function automatic logic req_illegal(input logic store, input logic [2:0] funct3);
        logic bad;
        case (funct3)
            F3_LB, F3_LH, F3_LW: bad = 1'b0;
            F3_LBU, F3_LHU:      bad = store;
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned address.
    function automatic logic req_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3[1:0])
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = |addr_lo;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: extracts and extends load data from a RAM
// word, and merges byte/halfword store data into the old word for RMW.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] store_data
);

    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] byte_mask;
    logic [DATA_WIDTH-1:0] half_mask;
    logic [DATA_WIDTH-1:0] byte_ins;
    logic [DATA_WIDTH-1:0] half_ins;
    logic [4:0]            byte_shift;
    logic [4:0]            half_shift;

    // Lane selection and load extension.
    always_comb begin
        byte_shift = {addr_lo, 3'b000};
        half_shift = {addr_lo[1], 4'b0000};

        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LH:   load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_LW:   load_data = rdata;
            F3_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_data = '0;
        endcase
    end

    // Store merge: only the addressed lanes take new data.
    always_comb begin
        byte_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << byte_shift;
        half_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << half_shift;
        byte_ins  = {{(DATA_WIDTH-8){1'b0}}, wdata[7:0]} << byte_shift;
        half_ins  = {{(DATA_WIDTH-16){1'b0}}, wdata[15:0]} << half_shift;

        case (funct3[1:0])
            2'b00:   store_data = (rdata & ~byte_mask) | byte_ins;
            2'b01:   store_data = (rdata & ~half_mask) | half_ins;
            default: store_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, talks to a single-port
// RAM with combinational read, and returns one response per request.
//
// state | meaning
// IDLE  | ready for a request
// READ  | RAM word read (load data or old word for byte/half store)
// WRITE | one-cycle RAM write
// RESP  | response held until consumer accepts
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic                  wEn,
    output logic [ADDR_WIDTH-1:0] d_address,
    output logic [DATA_WIDTH-1:0] d_write_data,
    input  logic [DATA_WIDTH-1:0] d_read_data
);

    lsu_state_t            state;
    logic                  store_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  resp_error_q;

    logic [DATA_WIDTH-1:0] align_rdata;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_data;
    logic                  req_bad;

    assign req_bad = req_illegal(req_store, req_funct3)
                   | req_misaligned(req_funct3, req_addr[1:0]);

    // During READ the live RAM word feeds extraction; during WRITE the
    // captured old word is the base for the merge.
    assign align_rdata = (state == READ) ? d_read_data : rdata_q;

    lsu_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .rdata      (align_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // Request capture, FSM sequencing and response registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            store_q      <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q  <= req_store;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        if (req_bad) begin
                            resp_rdata_q <= '0;
                            resp_error_q <= 1'b1;
                            state        <= RESP;
                        end else if (req_store && req_funct3 == F3_SW) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    rdata_q <= d_read_data;
                    if (!store_q) begin
                        resp_rdata_q <= load_data;
                        resp_error_q <= 1'b0;
                        state        <= RESP;
                    end else begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    resp_rdata_q <= '0;
                    resp_error_q <= 1'b0;
                    state        <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_rdata_q <= '0;
                        resp_error_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready    = (state == IDLE);
    assign resp_valid   = (state == RESP);
    assign resp_rdata   = resp_rdata_q;
    assign resp_error   = resp_error_q;

    // Reset gates the write strobe directly so a reset landing on a WRITE
    // cycle never reaches the RAM.
    assign wEn          = (state == WRITE) && reset;
    assign d_address    = (state == READ || state == WRITE)
                        ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign d_write_data = (state == WRITE) ? store_data : '0;

endmodule
